// File: rtl/p4_router_pkg.sv
// Shared types for the P4 router trTCM policer: colours, packet metadata,
// config-select encodings, and the metadata colour-overwrite helper.
package p4_router_pkg;

  typedef enum logic [1:0] {
    GREEN  = 2'd0,
    YELLOW = 2'd1,
    RED    = 2'd2
  } color_t;

  typedef enum logic [1:0] {
    CFG_CIR = 2'd0,
    CFG_PIR = 2'd1,
    CFG_CBS = 2'd2,
    CFG_PBS = 2'd3
  } cfg_sel_t;

  typedef enum logic {
    ST_SOP  = 1'b0,
    ST_BODY = 1'b1
  } pkt_state_t;

  localparam int MD_PORT_W = 8;
  localparam int MD_LEN_W  = 16;

  typedef struct packed {
    logic [MD_PORT_W-1:0] ingress_port;
    logic [MD_LEN_W-1:0]  byte_length;
    color_t               color;
  } metadata_t;

  function automatic metadata_t set_color(metadata_t md, color_t c);
    metadata_t r;
    r       = md;
    r.color = c;
    return r;
  endfunction

endpackage

// File: rtl/p4_router_trtcm_policer_if.sv
// AXI-Stream style beat bus carrying payload plus router metadata.
interface p4_router_trtcm_policer_if #(
  parameter int DATA_BYTES = 64
);
  import p4_router_pkg::*;

  logic                    tvalid;
  logic                    tready;
  logic                    tlast;
  logic [8*DATA_BYTES-1:0] tdata;
  metadata_t               tuser;

  modport master (output tvalid, tlast, tdata, tuser, input  tready);
  modport slave  (input  tvalid, tlast, tdata, tuser, output tready);

endinterface

// File: rtl/p4_router_trtcm_bucket.sv
// One port's committed/peak token buckets: refill, saturation at the burst
// size, SOP debit, and the "bucket below packet length" comparisons.
module p4_router_trtcm_bucket
  import p4_router_pkg::*;
#(
  parameter int LEN_W   = 16,
  parameter int FRAC_W  = 16,
  parameter int BURST_W = 20
) (
  input  logic                      clk,
  input  logic                      areset,
  input  logic                      en_i,
  input  logic [BURST_W+FRAC_W-1:0] cir_i,
  input  logic [BURST_W+FRAC_W-1:0] pir_i,
  input  logic [BURST_W-1:0]        cbs_i,
  input  logic [BURST_W-1:0]        pbs_i,
  input  logic [LEN_W-1:0]          len_i,
  input  logic                      dbt_c_i,
  input  logic                      dbt_p_i,
  output logic                      tc_lt_o,
  output logic                      tp_lt_o
);

  localparam int TW = BURST_W + FRAC_W;
  localparam int XW = TW + 1;

  logic [TW-1:0] tc_q, tc_d, tp_q, tp_d;
  logic [XW-1:0] len_x, cmax_x, pmax_x, tc_x, tp_x;

  assign len_x  = XW'({len_i, {FRAC_W{1'b0}}});
  assign cmax_x = {1'b0, cbs_i, {FRAC_W{1'b0}}};
  assign pmax_x = {1'b0, pbs_i, {FRAC_W{1'b0}}};

  assign tc_lt_o = ({1'b0, tc_q} < len_x);
  assign tp_lt_o = ({1'b0, tp_q} < len_x);

  // Debit is only raised when the bucket holds >= L, so the extra top bit
  // only has to absorb the refill carry before clipping.
  always_comb begin
    tc_x = {1'b0, tc_q} - (dbt_c_i ? len_x : '0) + {1'b0, cir_i};
    tp_x = {1'b0, tp_q} - (dbt_p_i ? len_x : '0) + {1'b0, pir_i};
    tc_d = cmax_x[TW-1:0];
    tp_d = pmax_x[TW-1:0];
    if (en_i) begin
      if (tc_x < cmax_x) tc_d = tc_x[TW-1:0];
      if (tp_x < pmax_x) tp_d = tp_x[TW-1:0];
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      tc_q <= '0;
      tp_q <= '0;
    end else begin
      tc_q <= tc_d;
      tp_q <= tp_d;
    end
  end

endmodule

// File: rtl/p4_router_trtcm_policer.sv
// Per-port two-rate three-colour policer in a single-stage register slice.
// Define P4_ROUTER_POLICER_COLOR_AWARE_EN to honour the incoming packet colour.
module p4_router_trtcm_policer
  import p4_router_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_BYTES = 64,
  parameter int LEN_W      = 16,
  parameter int FRAC_W     = 16,
  parameter int BURST_W    = 20,
  localparam int PIDX_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
  localparam int CFG_W     = BURST_W + FRAC_W
) (
  input  logic                 clk,
  input  logic                 areset,
  input  logic [NUM_PORTS-1:0] enable,
  input  logic                 cfg_wr,
  input  logic [PIDX_W-1:0]    cfg_port,
  input  logic [1:0]           cfg_sel,
  input  logic [CFG_W-1:0]     cfg_data,
  p4_router_trtcm_policer_if.slave  s,
  p4_router_trtcm_policer_if.master m
);

  logic [NUM_PORTS-1:0][CFG_W-1:0]   cir_q, pir_q;
  logic [NUM_PORTS-1:0][BURST_W-1:0] cbs_q, pbs_q;
  logic [NUM_PORTS-1:0]              tc_lt, tp_lt, dbt_c, dbt_p;

  pkt_state_t state_q, state_d;
  logic       s_ready, accept, is_sop, sop_acc;

  logic                    m_tvalid_q, m_tvalid_d, m_tlast_q, m_tlast_d;
  logic [8*DATA_BYTES-1:0] m_tdata_q, m_tdata_d;
  metadata_t               m_tuser_q, m_tuser_d;
  color_t                  color_q, color_d, sop_color, beat_color;

  logic [MD_PORT_W-1:0] pkt_port;
  logic [PIDX_W-1:0]    pidx;
  logic [LEN_W-1:0]     pkt_len;
  logic                 port_ok, dbt_c_sel, dbt_p_sel;

  assign s_ready  = m.tready | ~m_tvalid_q;
  assign s.tready = s_ready;
  assign accept   = s.tvalid & s_ready;

  // Packet framing FSM
  always_ff @(posedge clk or posedge areset) begin
    if (areset) state_q <= ST_SOP;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (accept) state_d = s.tlast ? ST_SOP : ST_BODY;
  end

  always_comb begin
    is_sop  = (state_q == ST_SOP);
    sop_acc = accept & is_sop;
  end

  assign pkt_port = s.tuser.ingress_port;
  assign pidx     = pkt_port[PIDX_W-1:0];
  assign pkt_len  = LEN_W'(s.tuser.byte_length);
  assign port_ok  = (32'(pkt_port) < 32'(NUM_PORTS));

  always_comb begin
    sop_color = GREEN;
    dbt_c_sel = 1'b0;
    dbt_p_sel = 1'b0;
    if (!port_ok) begin
      sop_color = RED;
    end else if (!enable[pidx]) begin
      sop_color = GREEN;
`ifdef P4_ROUTER_POLICER_COLOR_AWARE_EN
    end else if (s.tuser.color == RED) begin
      sop_color = RED;
    end else if (s.tuser.color == YELLOW) begin
      if (tp_lt[pidx]) begin
        sop_color = RED;
      end else begin
        sop_color = YELLOW;
        dbt_p_sel = 1'b1;
      end
`endif
    end else if (tp_lt[pidx]) begin
      sop_color = RED;
    end else if (tc_lt[pidx]) begin
      sop_color = YELLOW;
      dbt_p_sel = 1'b1;
    end else begin
      sop_color = GREEN;
      dbt_c_sel = 1'b1;
      dbt_p_sel = 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    assign dbt_c[i] = sop_acc & dbt_c_sel & (pidx == PIDX_W'(i));
    assign dbt_p[i] = sop_acc & dbt_p_sel & (pidx == PIDX_W'(i));

    p4_router_trtcm_bucket #(
      .LEN_W   (LEN_W),
      .FRAC_W  (FRAC_W),
      .BURST_W (BURST_W)
    ) u_bkt (
      .clk     (clk),
      .areset  (areset),
      .en_i    (enable[i]),
      .cir_i   (cir_q[i]),
      .pir_i   (pir_q[i]),
      .cbs_i   (cbs_q[i]),
      .pbs_i   (pbs_q[i]),
      .len_i   (pkt_len),
      .dbt_c_i (dbt_c[i]),
      .dbt_p_i (dbt_p[i]),
      .tc_lt_o (tc_lt[i]),
      .tp_lt_o (tp_lt[i])
    );
  end

  // Buckets read registered config, so a same-cycle debit sees old values.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      cir_q <= '0;
      pir_q <= '0;
      cbs_q <= '0;
      pbs_q <= '0;
    end else if (cfg_wr && (32'(cfg_port) < 32'(NUM_PORTS))) begin
      case (cfg_sel_t'(cfg_sel))
        CFG_CIR: cir_q[cfg_port] <= cfg_data;
        CFG_PIR: pir_q[cfg_port] <= cfg_data;
        CFG_CBS: cbs_q[cfg_port] <= cfg_data[CFG_W-1:FRAC_W];
        CFG_PBS: pbs_q[cfg_port] <= cfg_data[CFG_W-1:FRAC_W];
      endcase
    end
  end

  assign beat_color = is_sop ? sop_color : color_q;

  always_comb begin
    m_tvalid_d = m_tvalid_q;
    m_tlast_d  = m_tlast_q;
    m_tdata_d  = m_tdata_q;
    m_tuser_d  = m_tuser_q;
    color_d    = color_q;
    if (s_ready) m_tvalid_d = s.tvalid;
    if (accept) begin
      m_tlast_d = s.tlast;
      m_tdata_d = s.tdata;
      m_tuser_d = set_color(s.tuser, beat_color);
    end
    if (sop_acc) color_d = sop_color;
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      m_tvalid_q <= 1'b0;
      m_tlast_q  <= 1'b0;
      m_tdata_q  <= '0;
      m_tuser_q  <= '0;
      color_q    <= GREEN;
    end else begin
      m_tvalid_q <= m_tvalid_d;
      m_tlast_q  <= m_tlast_d;
      m_tdata_q  <= m_tdata_d;
      m_tuser_q  <= m_tuser_d;
      color_q    <= color_d;
    end
  end

  assign m.tvalid = m_tvalid_q;
  assign m.tlast  = m_tlast_q;
  assign m.tdata  = m_tdata_q;
  assign m.tuser  = m_tuser_q;

endmodule

// File: tb/tb_p4_router_trtcm_policer.sv
// Directed bench for the trTCM policer: colour sequences, refill, disable,
// stall, bad port, colour mode, burst clip and mid-packet reset.
module tb_p4_router_trtcm_policer;
  import p4_router_pkg::*;

  localparam int NP = 4;
  localparam int DB = 64;
  localparam int FW = 16;
  localparam int BW = 20;
  localparam int CW = BW + FW;

  logic          clk = 1'b0;
  logic          areset = 1'b1;
  logic [NP-1:0] enable;
  logic          cfg_wr;
  logic [1:0]    cfg_port;
  logic [1:0]    cfg_sel;
  logic [CW-1:0] cfg_data;

  p4_router_trtcm_policer_if #(.DATA_BYTES(DB)) s_if();
  p4_router_trtcm_policer_if #(.DATA_BYTES(DB)) m_if();

  p4_router_trtcm_policer #(
    .NUM_PORTS(NP), .DATA_BYTES(DB), .LEN_W(16), .FRAC_W(FW), .BURST_W(BW)
  ) dut (
    .clk(clk), .areset(areset), .enable(enable), .cfg_wr(cfg_wr),
    .cfg_port(cfg_port), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .s(s_if), .m(m_if)
  );

  always #5 clk = ~clk;

  logic [CW-1:0] tc0, tp0, tc1, tp1;
  assign tc0 = dut.g_port[0].u_bkt.tc_q;
  assign tp0 = dut.g_port[0].u_bkt.tp_q;
  assign tc1 = dut.g_port[1].u_bkt.tc_q;
  assign tp1 = dut.g_port[1].u_bkt.tp_q;

  int checks = 0;
  int errors = 0;

  function automatic logic [CW-1:0] tok(input int n);
    return CW'(n) << FW;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int p, input int sel, input logic [CW-1:0] d);
    cfg_wr   = 1'b1;
    cfg_port = p[1:0];
    cfg_sel  = sel[1:0];
    cfg_data = d;
    tick();
    cfg_wr   = 1'b0;
  endtask

  // Holding a port disabled loads both buckets to their burst sizes.
  task automatic fill(input int p);
    enable[p] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    enable[p] = 1'b1;
  endtask

  task automatic drive_beat(input int port, input int len, input color_t col,
                            input logic last, input int data);
    s_if.tvalid             = 1'b1;
    s_if.tlast              = last;
    s_if.tdata              = {16{32'(data)}};
    s_if.tuser.ingress_port = port[7:0];
    s_if.tuser.byte_length  = len[15:0];
    s_if.tuser.color        = col;
  endtask

  task automatic idle();
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (s_if.tready !== 1'b1) begin errors++; $display("FAIL reset_s_tready got %0b want 1", s_if.tready); end
    checks++; if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL reset_m_tvalid got %0b want 0", m_if.tvalid); end
    checks++; if (m_if.tlast !== 1'b0) begin errors++; $display("FAIL reset_m_tlast got %0b want 0", m_if.tlast); end
    checks++; if (m_if.tdata !== '0) begin errors++; $display("FAIL reset_m_tdata got %h want 0", m_if.tdata[31:0]); end
    checks++; if (m_if.tuser !== '0) begin errors++; $display("FAIL reset_m_tuser got %h want 0", m_if.tuser); end
    checks++; if (tc0 !== '0) begin errors++; $display("FAIL reset_tc0 got %h want 0", tc0); end
    areset = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    color_t exp_c [3] = '{GREEN, YELLOW, RED};
    cfg_write(0, 0, tok(1));
    cfg_write(0, 1, tok(2));
    cfg_write(0, 2, tok(1500));
    cfg_write(0, 3, tok(3000));
    fill(0);
    checks++; if (tc0 !== tok(1500)) begin errors++; $display("FAIL b2b_full_tc got %h want %h", tc0, tok(1500)); end
    checks++; if (tp0 !== tok(3000)) begin errors++; $display("FAIL b2b_full_tp got %h want %h", tp0, tok(3000)); end
    for (int i = 0; i < 3; i++) begin
      drive_beat(0, 1500, GREEN, 1'b1, i);
      tick();
      checks++; if (m_if.tvalid !== 1'b1 || m_if.tuser.color !== exp_c[i])
        begin errors++; $display("FAIL b2b_color%0d got v=%0b c=%0d want v=1 c=%0d", i, m_if.tvalid, m_if.tuser.color, exp_c[i]); end
    end
    idle();
    // Each debit cycle also refills CIR=1, PIR=2.
    checks++; if (tc0 !== tok(3)) begin errors++; $display("FAIL b2b_tc_after got %h want %h", tc0, tok(3)); end
    checks++; if (tp0 !== tok(6)) begin errors++; $display("FAIL b2b_tp_after got %h want %h", tp0, tok(6)); end
  endtask

  task automatic test_idle_refill();
    repeat (1500) @(posedge clk);
    #1;
    checks++; if (tc0 !== tok(1500)) begin errors++; $display("FAIL idle_tc_sat got %h want %h", tc0, tok(1500)); end
    checks++; if (tp0 !== tok(3000)) begin errors++; $display("FAIL idle_tp_sat got %h want %h", tp0, tok(3000)); end
    drive_beat(0, 1500, GREEN, 1'b1, 7);
    tick();
    idle();
    checks++; if (m_if.tuser.color !== GREEN) begin errors++; $display("FAIL idle_color got %0d want %0d", m_if.tuser.color, GREEN); end
    // 1500-1500 plus one cycle of refill; 3000-1500 plus two.
    checks++; if (tc0 !== tok(1)) begin errors++; $display("FAIL idle_tc got %h want %h", tc0, tok(1)); end
    checks++; if (tp0 !== tok(1502)) begin errors++; $display("FAIL idle_tp got %h want %h", tp0, tok(1502)); end
  endtask

  task automatic test_disabled();
    cfg_write(1, 0, tok(1));
    cfg_write(1, 1, tok(2));
    cfg_write(1, 2, tok(1000));
    cfg_write(1, 3, tok(2000));
    tick();
    checks++; if (tc1 !== tok(1000)) begin errors++; $display("FAIL dis_tc_init got %h want %h", tc1, tok(1000)); end
    checks++; if (tp1 !== tok(2000)) begin errors++; $display("FAIL dis_tp_init got %h want %h", tp1, tok(2000)); end
    for (int i = 0; i < 10; i++) begin
      drive_beat(1, 9000, GREEN, 1'b1, 20 + i);
      tick();
      checks++; if (m_if.tuser.color !== GREEN) begin errors++; $display("FAIL dis_color%0d got %0d want %0d", i, m_if.tuser.color, GREEN); end
    end
    idle();
    checks++; if (tc1 !== tok(1000)) begin errors++; $display("FAIL dis_tc_after got %h want %h", tc1, tok(1000)); end
    checks++; if (tp1 !== tok(2000)) begin errors++; $display("FAIL dis_tp_after got %h want %h", tp1, tok(2000)); end
  endtask

  task automatic test_stall();
    logic [8*DB-1:0] expd;
    cfg_write(0, 0, '0);
    cfg_write(0, 1, '0);
    fill(0);
    // Tc=1500 < 2000 <= Tp=3000: YELLOW, body beats carry len 0 / GREEN.
    for (int b = 0; b < 3; b++) begin
      drive_beat(0, (b == 0) ? 2000 : 0, GREEN, 1'b0, 100 + b);
      tick();
      expd = {16{32'(100 + b)}};
      checks++; if (m_if.tdata !== expd) begin errors++; $display("FAIL stall_data%0d got %h want %h", b, m_if.tdata[31:0], expd[31:0]); end
      checks++; if (m_if.tuser.color !== YELLOW) begin errors++; $display("FAIL stall_color%0d got %0d want %0d", b, m_if.tuser.color, YELLOW); end
    end
    m_if.tready = 1'b0;
    drive_beat(0, 0, GREEN, 1'b1, 103);
    expd = {16{32'(102)}};
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (m_if.tvalid !== 1'b1 || m_if.tdata !== expd || m_if.tlast !== 1'b0)
        begin errors++; $display("FAIL stall_hold%0d got v=%0b l=%0b d=%h want v=1 l=0 d=%h", c, m_if.tvalid, m_if.tlast, m_if.tdata[31:0], expd[31:0]); end
      checks++; if (m_if.tuser.color !== YELLOW) begin errors++; $display("FAIL stall_hold_color%0d got %0d want %0d", c, m_if.tuser.color, YELLOW); end
      checks++; if (s_if.tready !== 1'b0) begin errors++; $display("FAIL stall_s_tready%0d got %0b want 0", c, s_if.tready); end
    end
    m_if.tready = 1'b1;
    tick();
    idle();
    expd = {16{32'(103)}};
    checks++; if (m_if.tdata !== expd || m_if.tlast !== 1'b1)
      begin errors++; $display("FAIL stall_last got l=%0b d=%h want l=1 d=%h", m_if.tlast, m_if.tdata[31:0], expd[31:0]); end
    checks++; if (m_if.tuser.color !== YELLOW) begin errors++; $display("FAIL stall_last_color got %0d want %0d", m_if.tuser.color, YELLOW); end
    checks++; if (tc0 !== tok(1500)) begin errors++; $display("FAIL stall_tc got %h want %h", tc0, tok(1500)); end
    checks++; if (tp0 !== tok(1000)) begin errors++; $display("FAIL stall_tp got %h want %h", tp0, tok(1000)); end
  endtask

  task automatic test_bad_port();
    drive_beat(NP, 10, GREEN, 1'b1, 55);
    tick();
    idle();
    checks++; if (m_if.tuser.color !== RED) begin errors++; $display("FAIL badport_color got %0d want %0d", m_if.tuser.color, RED); end
    checks++; if (tc0 !== tok(1500) || tp0 !== tok(1000))
      begin errors++; $display("FAIL badport_p0 got tc=%h tp=%h want tc=%h tp=%h", tc0, tp0, tok(1500), tok(1000)); end
    checks++; if (tc1 !== tok(1000) || tp1 !== tok(2000))
      begin errors++; $display("FAIL badport_p1 got tc=%h tp=%h want tc=%h tp=%h", tc1, tp1, tok(1000), tok(2000)); end
  endtask

  task automatic test_color_mode();
    color_t   c_y, c_r;
    int       tc_y, tp_y, tc_r, tp_r;
`ifdef P4_ROUTER_POLICER_COLOR_AWARE_EN
    c_y = YELLOW; tc_y = 3000; tp_y = 2900;
    c_r = RED;    tc_r = 3000; tp_r = 2900;
`else
    c_y = GREEN;  tc_y = 2900; tp_y = 2900;
    c_r = GREEN;  tc_r = 2800; tp_r = 2800;
`endif
    cfg_write(0, 2, tok(3000));
    fill(0);
    drive_beat(0, 100, YELLOW, 1'b1, 60);
    tick();
    checks++; if (m_if.tuser.color !== c_y) begin errors++; $display("FAIL cmode_yellow got %0d want %0d", m_if.tuser.color, c_y); end
    checks++; if (tc0 !== tok(tc_y) || tp0 !== tok(tp_y))
      begin errors++; $display("FAIL cmode_yellow_tok got tc=%h tp=%h want tc=%h tp=%h", tc0, tp0, tok(tc_y), tok(tp_y)); end
    drive_beat(0, 100, RED, 1'b1, 61);
    tick();
    idle();
    checks++; if (m_if.tuser.color !== c_r) begin errors++; $display("FAIL cmode_red got %0d want %0d", m_if.tuser.color, c_r); end
    checks++; if (tc0 !== tok(tc_r) || tp0 !== tok(tp_r))
      begin errors++; $display("FAIL cmode_red_tok got tc=%h tp=%h want tc=%h tp=%h", tc0, tp0, tok(tc_r), tok(tp_r)); end
  endtask

  task automatic test_clip();
    logic [CW-1:0] tp_before;
    tp_before = tp0;
    cfg_write(0, 2, tok(500));
    tick();
    checks++; if (tc0 !== tok(500)) begin errors++; $display("FAIL clip_tc got %h want %h", tc0, tok(500)); end
    checks++; if (tp0 !== tp_before) begin errors++; $display("FAIL clip_tp got %h want %h", tp0, tp_before); end
  endtask

  task automatic test_reset_mid();
    drive_beat(0, 10, GREEN, 1'b0, 70);
    tick();
    #2;
    areset = 1'b1;
    #1;
    checks++; if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL rmid_async_tvalid got %0b want 0", m_if.tvalid); end
    checks++; if (s_if.tready !== 1'b1) begin errors++; $display("FAIL rmid_s_tready got %0b want 1", s_if.tready); end
    checks++; if (tc0 !== '0 || tp0 !== '0) begin errors++; $display("FAIL rmid_tok got tc=%h tp=%h want 0", tc0, tp0); end
    @(posedge clk);
    #1;
    areset = 1'b0;
    // Config is cleared, so an SOP evaluation sees Tp=0 < 10 and goes RED.
    drive_beat(0, 10, GREEN, 1'b1, 71);
    tick();
    idle();
    checks++; if (m_if.tvalid !== 1'b1 || m_if.tuser.color !== RED)
      begin errors++; $display("FAIL rmid_sop got v=%0b c=%0d want v=1 c=%0d", m_if.tvalid, m_if.tuser.color, RED); end
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    enable      = '0;
    cfg_wr      = 1'b0;
    cfg_port    = '0;
    cfg_sel     = '0;
    cfg_data    = '0;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    s_if.tdata  = '0;
    s_if.tuser  = '0;
    m_if.tready = 1'b1;
    test_reset();
    test_back_to_back();
    test_idle_refill();
    test_disabled();
    test_stall();
    test_bad_port();
    test_color_mode();
    test_clip();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
